// File: rtl/bcd_conv_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives the conversion request, the slave (converter) returns results.
interface bcd_conv_seq_if #(
    parameter int DATA_W = 20,
    parameter int DIG_N  = 6
);
    logic                 start;
    logic [DATA_W-1:0]    data_in;
    logic                 busy;
    logic                 done;
    logic [4*DIG_N-1:0]   bcd_out;
    logic                 sign;
    logic [DIG_N-1:0]     blank_mask;
    logic                 ovf;

    modport master (
        output start, data_in,
        input  busy, done, bcd_out, sign, blank_mask, ovf
    );

    modport slave (
        input  start, data_in,
        output busy, done, bcd_out, sign, blank_mask, ovf
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary-to-BCD converter: one ADJ/SHIFT pair per input bit,
// with sign handling, leading-zero blanking and saturating overflow.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// ADJ   | add 3 to every BCD nibble that is >= 5
// SHIFT | shift the whole register left one bit, count the iteration
// FIN   | publish the result; done pulses on the following cycle
module bcd_conv_seq #(
    parameter int DATA_W    = 20,
    parameter int DIG_N     = 6,
    parameter int SIGNED_EN = 0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    bcd_conv_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIG_N;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, ADJ, SHIFT, FIN} state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               neg_q, neg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic [DIG_N-1:0]   blank_q, blank_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               in_neg;
    logic [DATA_W-1:0]  in_mag;
    logic [SR_W-1:0]    sr_adj;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   sat_val;
    logic [DIG_N-1:0]   blank_c;

    always_comb begin
        in_neg = (SIGNED_EN != 0) && bus.data_in[DATA_W-1];
        in_mag = in_neg ? (~bus.data_in + DATA_W'(1)) : bus.data_in;
    end

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIG_N; i++) begin
            if (sr_q[DATA_W+4*i +: 4] >= 4'd5)
                sr_adj[DATA_W+4*i +: 4] = sr_q[DATA_W+4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero scan from the top digit down; the units digit is never blanked.
    always_comb begin
        logic hz;
        digits  = sr_q[SR_W-1 -: BCD_W];
        hz      = 1'b1;
        blank_c = '0;
        sat_val = '0;
        for (int i = 0; i < DIG_N; i++)
            sat_val[4*i +: 4] = 4'h9;
        for (int i = DIG_N - 1; i >= 1; i--) begin
            hz         = hz && (digits[4*i +: 4] == 4'd0);
            blank_c[i] = hz;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        blank_d   = blank_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d      = {{BCD_W{1'b0}}, in_mag};
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    neg_d     = in_neg;
                    state_d   = ADJ;
                end
            end
            ADJ: begin
                sr_d    = sr_adj;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d      = {sr_q[SR_W-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | sr_q[SR_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = (cnt_q == CNT_W'(DATA_W - 1)) ? FIN : ADJ;
            end
            FIN: begin
                bcd_d   = ovf_acc_q ? sat_val : digits;
                blank_d = ovf_acc_q ? '0 : blank_c;
                sign_d  = neg_q;
                ovf_d   = ovf_acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            blank_q   <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.sign       = sign_q;
    assign bus.blank_mask = blank_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed-vector bench: an unsigned 20-bit/6-digit converter and a signed 8-bit/3-digit one
// share clock and reset; results, latency and handshake corner cases are checked.
module tb_bcd_conv_seq;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bcd_conv_seq_if #(.DATA_W(20), .DIG_N(6)) if_a ();
    bcd_conv_seq_if #(.DATA_W(8),  .DIG_N(3)) if_b ();

    bcd_conv_seq #(.DATA_W(20), .DIG_N(6), .SIGNED_EN(0)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if_a)
    );
    bcd_conv_seq #(.DATA_W(8), .DIG_N(3), .SIGNED_EN(1)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;     // 0 = unsigned 20-bit DUT, 1 = signed 8-bit DUT
        logic [19:0] din;
        logic [23:0] bcd;
        logic [5:0]  blank;
        bit          sgn;
        bit          ov;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one conversion; data_in is scrambled right after the accepting edge.
    task automatic run_a(input logic [19:0] d, output int lat);
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = d;
        @(negedge clk);
        if_a.start   = 1'b0;
        if_a.data_in = ~d;
        lat = 0;
        while (!if_a.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_b(input logic [7:0] d, output int lat);
        @(negedge clk);
        if_b.start   = 1'b1;
        if_b.data_in = d;
        @(negedge clk);
        if_b.start   = 1'b0;
        if_b.data_in = ~d;
        lat = 0;
        while (!if_b.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_done_a(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if_a.done) n++;
        end
    endtask

    initial begin
        int lat;
        int lat2;
        int nd;

        vecs[0]  = '{0, 20'd0,       24'h000000, 6'b111110, 0, 0};
        vecs[1]  = '{0, 20'd1234,    24'h001234, 6'b110000, 0, 0};
        vecs[2]  = '{0, 20'd999999,  24'h999999, 6'b000000, 0, 0};
        vecs[3]  = '{0, 20'hFFFFF,   24'h999999, 6'b000000, 0, 1};
        vecs[4]  = '{0, 20'd1000000, 24'h999999, 6'b000000, 0, 1};
        vecs[5]  = '{0, 20'd7,       24'h000007, 6'b111110, 0, 0};
        vecs[6]  = '{0, 20'd100000,  24'h100000, 6'b000000, 0, 0};
        vecs[7]  = '{0, 20'd90,      24'h000090, 6'b111100, 0, 0};
        vecs[8]  = '{1, 20'h80,      24'h000128, 6'b000000, 1, 0};
        vecs[9]  = '{1, 20'hFF,      24'h000001, 6'b000110, 1, 0};
        vecs[10] = '{1, 20'h7F,      24'h000127, 6'b000000, 0, 0};
        vecs[11] = '{1, 20'h00,      24'h000000, 6'b000110, 0, 0};
        vecs[12] = '{1, 20'hF6,      24'h000010, 6'b000100, 1, 0};

        rst_n        = 1'b0;
        if_a.start   = 1'b0;
        if_a.data_in = '0;
        if_b.start   = 1'b0;
        if_b.data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(if_a.busy), 64'(0));
        chk("rst_done",  64'(if_a.done), 64'(0));
        chk("rst_bcd",   64'(if_a.bcd_out), 64'(0));
        chk("rst_blank", 64'(if_a.blank_mask), 64'(0));
        chk("rst_ovf_sign", 64'({if_a.ovf, if_a.sign, if_b.sign}), 64'(0));
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            if (!vecs[v].sel) begin
                run_a(vecs[v].din, lat);
                chk($sformatf("v%0d_latency", v), 64'(lat), 64'(41));
                chk($sformatf("v%0d_bcd", v), 64'(if_a.bcd_out), 64'(vecs[v].bcd));
                chk($sformatf("v%0d_blank", v), 64'(if_a.blank_mask), 64'(vecs[v].blank));
                chk($sformatf("v%0d_sign_ovf", v), 64'({if_a.sign, if_a.ovf}),
                    64'({vecs[v].sgn, vecs[v].ov}));
                @(negedge clk);
                chk($sformatf("v%0d_done_pulse", v), 64'({if_a.done, if_a.busy}), 64'(0));
            end else begin
                run_b(vecs[v].din[7:0], lat);
                chk($sformatf("v%0d_latency", v), 64'(lat), 64'(17));
                chk($sformatf("v%0d_bcd", v), 64'(if_b.bcd_out), 64'(vecs[v].bcd[11:0]));
                chk($sformatf("v%0d_blank", v), 64'(if_b.blank_mask), 64'(vecs[v].blank[2:0]));
                chk($sformatf("v%0d_sign_ovf", v), 64'({if_b.sign, if_b.ovf}),
                    64'({vecs[v].sgn, vecs[v].ov}));
                @(negedge clk);
                chk($sformatf("v%0d_done_pulse", v), 64'({if_b.done, if_b.busy}), 64'(0));
            end
        end

        // start re-pulsed mid-conversion must be ignored
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = 20'd1234;
        @(negedge clk);
        if_a.start = 1'b0;
        lat = 0;
        repeat (9) begin
            @(negedge clk);
            lat++;
        end
        if_a.start   = 1'b1;
        if_a.data_in = 20'd555;
        @(negedge clk);
        lat++;
        if_a.start = 1'b0;
        while (!if_a.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("repulse_latency", 64'(lat), 64'(41));
        chk("repulse_bcd", 64'(if_a.bcd_out), 64'(24'h001234));
        count_done_a(60, nd);
        chk("repulse_single_done", 64'(nd), 64'(0));
        chk("hold_bcd", 64'(if_a.bcd_out), 64'(24'h001234));
        chk("hold_blank", 64'(if_a.blank_mask), 64'(6'b110000));

        // start held through the done cycle: back-to-back conversions 42 cycles apart
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = 20'd42;
        @(negedge clk);
        if_a.data_in = 20'd777;
        lat = 0;
        while (!if_a.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 64'(lat), 64'(41));
        chk("b2b_first_bcd", 64'(if_a.bcd_out), 64'(24'h000042));
        @(negedge clk);
        if_a.start = 1'b0;
        chk("b2b_second_busy", 64'(if_a.busy), 64'(1));
        lat2 = 1;
        while (!if_a.done && lat2 < 200) begin
            @(negedge clk);
            lat2++;
        end
        chk("b2b_done_spacing", 64'(lat2), 64'(42));
        chk("b2b_second_bcd", 64'(if_a.bcd_out), 64'(24'h000777));
        chk("b2b_second_blank", 64'(if_a.blank_mask), 64'(6'b111000));

        // reset in the middle of a conversion aborts it
        @(negedge clk);
        if_a.start   = 1'b1;
        if_a.data_in = 20'd999999;
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(if_a.busy), 64'(0));
        chk("abort_bcd", 64'(if_a.bcd_out), 64'(0));
        chk("abort_blank", 64'(if_a.blank_mask), 64'(0));
        chk("abort_flags", 64'({if_a.done, if_a.ovf, if_a.sign}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        count_done_a(60, nd);
        chk("abort_no_done", 64'(nd), 64'(0));
        run_a(20'd86420, lat);
        chk("post_reset_latency", 64'(lat), 64'(41));
        chk("post_reset_bcd", 64'(if_a.bcd_out), 64'(24'h086420));
        chk("post_reset_blank", 64'(if_a.blank_mask), 64'(6'b100000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
